// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, PC constants and FSM state type for the fetch sequencer
package fetch_ctrl_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} fetch_state_e;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: control, imem request/response and ifq write signals of the fetch sequencer
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;
    logic            fetch_en;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            ifq_wr_en;
    logic [XLEN-1:0] ifq_instr;
    logic [XLEN-1:0] ifq_pc;
    logic            ifq_flush;
    logic            ifq_full;
    logic [31:0]     fetch_count;
    modport master (
        input  fetch_en, redirect_valid, redirect_pc, imem_req_ready,
               imem_resp_valid, imem_resp_data, ifq_full,
        output imem_req_valid, imem_req_addr, ifq_wr_en, ifq_instr, ifq_pc,
               ifq_flush, fetch_count
    );
    modport slave (
        output fetch_en, redirect_valid, redirect_pc, imem_req_ready,
               imem_resp_valid, imem_resp_data, ifq_full,
        input  imem_req_valid, imem_req_addr, ifq_wr_en, ifq_instr, ifq_pc,
               ifq_flush, fetch_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer feeding the ifq,
// with backpressure hold, redirect flush and stale-response draining
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);
    fetch_state_e    state_q, state_d, resume;
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d, hold_q, hold_d;
    logic [31:0]     count_q, count_d;
    logic            wr_en, in_flight;

    assign wr_en = !bus.redirect_valid && !bus.ifq_full &&
                   ((state_q == S_WAIT && bus.imem_resp_valid) || state_q == S_HOLD);
    assign resume = bus.fetch_en ? S_REQ : S_IDLE;
    // a request accepted this cycle, or one still awaiting its response, must be drained
    assign in_flight = ((state_q == S_WAIT || state_q == S_DRAIN) && !bus.imem_resp_valid) ||
                       (state_q == S_REQ && bus.imem_req_ready);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        hold_d   = hold_q;
        count_d  = count_q;
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc & PC_ALIGN_MASK;
            hold_d  = '0;
            state_d = in_flight ? S_DRAIN : resume;
        end else begin
            case (state_q)
                S_IDLE:  state_d = bus.fetch_en ? S_REQ : S_IDLE;
                S_REQ: begin
                    req_pc_d = bus.imem_req_ready ? pc_q : req_pc_q;
                    state_d  = bus.imem_req_ready ? S_WAIT : resume;
                end
                S_WAIT: begin
                    hold_d  = (bus.imem_resp_valid && bus.ifq_full) ? bus.imem_resp_data : hold_q;
                    state_d = !bus.imem_resp_valid ? S_WAIT : bus.ifq_full ? S_HOLD : resume;
                end
                S_HOLD:  state_d = bus.ifq_full ? S_HOLD : resume;
                S_DRAIN: state_d = bus.imem_resp_valid ? resume : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
            if (wr_en) begin
                pc_d    = req_pc_q + PC_STEP;
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            hold_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            hold_q   <= hold_d;
            count_q  <= count_d;
        end
    end

    assign bus.imem_req_valid = state_q == S_REQ;
    assign bus.imem_req_addr  = pc_q;
    assign bus.ifq_wr_en      = wr_en;
    assign bus.ifq_instr      = !wr_en ? '0 : (state_q == S_HOLD) ? hold_q : bus.imem_resp_data;
    assign bus.ifq_pc         = wr_en ? req_pc_q : '0;
    assign bus.ifq_flush      = bus.redirect_valid;
    assign bus.fetch_count    = count_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic, checked against a
// transaction-level model of outstanding requests and words awaiting the ifq
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int errs = 0;

    fetch_ctrl_if bus();
    fetch_ctrl #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // model: one outstanding memory read, one word waiting for ifq space
    bit          infl, stale, pend, seen_wr;
    logic [31:0] infl_addr, pend_pc, pend_dat, nxt, cnt, wr_pc, c0;
    int          tmr, lat_lo, lat_hi;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.fetch_en = 0; bus.redirect_valid = 0; bus.redirect_pc = '0;
        bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = '0;
        bus.ifq_full = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        chk("rst_wr_en", 32'(bus.ifq_wr_en), 0);
        chk("rst_instr", bus.ifq_instr, 0);
        chk("rst_pc", bus.ifq_pc, 0);
        chk("rst_flush", 32'(bus.ifq_flush), 0);
        chk("rst_count", bus.fetch_count, 0);
        infl = 0; stale = 0; pend = 0; tmr = 0; nxt = 32'h0; cnt = 0;
    endtask

    task automatic step(input logic fe, input logic rdy, input logic full,
                        input logic rv, input logic [31:0] rpc);
        logic        resp, cand, wr_exp, hs;
        logic [31:0] cpc, cdat;
        resp = infl && tmr == 0;
        bus.fetch_en = fe; bus.imem_req_ready = rdy; bus.ifq_full = full;
        bus.redirect_valid = rv; bus.redirect_pc = rpc;
        bus.imem_resp_valid = resp;
        bus.imem_resp_data = resp ? mem_word(infl_addr) : $urandom;
        #1;
        cand = pend || (resp && !stale && !rv);
        cpc = pend ? pend_pc : infl_addr;
        cdat = pend ? pend_dat : mem_word(infl_addr);
        wr_exp = cand && !full && !rv;
        chk("flush", 32'(bus.ifq_flush), 32'(rv));
        chk("wr_en", 32'(bus.ifq_wr_en), 32'(wr_exp));
        if (wr_exp) begin
            chk("ifq_pc", bus.ifq_pc, cpc);
            chk("ifq_instr", bus.ifq_instr, cdat);
        end
        chk("count", bus.fetch_count, cnt);
        if (bus.imem_req_valid) begin
            chk("req_addr", bus.imem_req_addr, nxt);
            chk("one_outstanding", 32'(infl || pend), 0);
        end
        seen_wr = bus.ifq_wr_en;
        if (seen_wr) wr_pc = bus.ifq_pc;
        hs = bus.imem_req_valid && rdy;
        if (resp) infl = 0;
        if (wr_exp) begin
            cnt++; nxt = cpc + 32'd4; pend = 0;
        end else if (cand && !pend) begin
            pend = 1; pend_pc = cpc; pend_dat = cdat;
        end
        if (rv) begin
            pend = 0; stale = 1; nxt = rpc & ~32'h3;
        end
        if (hs) begin
            infl = 1; infl_addr = bus.imem_req_addr; stale = rv;
            tmr = int'($urandom_range(lat_hi, lat_lo));
        end else if (infl && tmr > 0) tmr--;
        @(negedge clk);
    endtask

    initial begin
        int k;
        lat_lo = 0; lat_hi = 0;
        do_reset();
        // 1: streaming fetch from RESET_PC
        k = 0;
        while (cnt != 3 && k < 40) begin step(1, 1, 0, 0, 0); k++; end
        chk("t1_count", bus.fetch_count, 32'd3);
        // 2: ifq full when the word for 0x10 returns
        k = 0;
        while (!(infl && infl_addr == 32'h10) && k < 40) begin step(1, 1, 0, 0, 0); k++; end
        chk("t2_req", infl_addr, 32'h10);
        repeat (4) step(1, 1, 1, 0, 0);
        chk("t2_held_count", bus.fetch_count, 32'd4);
        step(1, 1, 0, 0, 0);
        chk("t2_wr", 32'(seen_wr), 1);
        chk("t2_wr_pc", wr_pc, 32'h10);
        chk("t2_next_valid", 32'(bus.imem_req_valid), 1);
        chk("t2_next_addr", bus.imem_req_addr, 32'h14);
        // 3: redirect while waiting for a slow response
        lat_lo = 2; lat_hi = 2;
        k = 0;
        while (!infl && k < 20) begin step(1, 1, 0, 0, 0); k++; end
        c0 = cnt;
        step(1, 1, 0, 1, 32'h103);
        k = 0;
        while (!bus.imem_req_valid && k < 20) begin step(1, 0, 0, 0, 0); k++; end
        chk("t3_addr", bus.imem_req_addr, 32'h100);
        chk("t3_count", bus.fetch_count, c0);
        lat_lo = 0; lat_hi = 0;
        // 4: redirect while holding a word for a full ifq
        k = 0;
        while (!infl && k < 20) begin step(1, 1, 0, 0, 0); k++; end
        c0 = cnt;
        step(1, 0, 1, 0, 0);
        chk("t4_held_count", bus.fetch_count, c0);
        step(1, 0, 1, 1, 32'h200);
        chk("t4_valid", 32'(bus.imem_req_valid), 1);
        chk("t4_addr", bus.imem_req_addr, 32'h200);
        chk("t4_count", bus.fetch_count, c0);
        // 5: stalled request then fetch_en drop
        repeat (5) begin
            step(1, 0, 0, 0, 0);
            chk("t5_valid_held", 32'(bus.imem_req_valid), 1);
            chk("t5_addr_stable", bus.imem_req_addr, 32'h200);
        end
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("t5_wr_pc", wr_pc, 32'h200);
        repeat (6) begin
            step(0, 1, 0, 0, 0);
            chk("t5_idle", 32'(bus.imem_req_valid), 0);
        end
        // PC wrap at the top of the address space
        step(1, 0, 0, 1, 32'hFFFF_FFFF);
        c0 = cnt; k = 0;
        while (cnt == c0 && k < 20) begin step(1, 1, 0, 0, 0); k++; end
        chk("wrap_wr_pc", wr_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", bus.imem_req_addr, 32'h0);
        // 6: reset while a request is in flight; its late response is ignored
        step(1, 1, 0, 0, 0);
        do_reset();
        bus.imem_resp_valid = 1; bus.imem_resp_data = 32'h1234_5678;
        #1;
        chk("t6_late_wr", 32'(bus.ifq_wr_en), 0);
        chk("t6_late_instr", bus.ifq_instr, 0);
        @(negedge clk);
        bus.imem_resp_valid = 0;
        chk("t6_count", bus.fetch_count, 0);
        step(1, 1, 0, 0, 0);
        chk("t6_valid", 32'(bus.imem_req_valid), 1);
        chk("t6_addr", bus.imem_req_addr, 32'h0);
        // randomized traffic
        lat_lo = 0; lat_hi = 2;
        repeat (3000)
            step($urandom_range(7, 0) != 0, $urandom_range(1, 0) == 1,
                 $urandom_range(2, 0) == 0, $urandom_range(15, 0) == 0, $urandom);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
